// File: rtl/zeroriscy_host_mmio.sv
// -----------------------------------------------------------------------------
// zeroriscy_host_mmio
// Host-interface slave on the zero-riscy data port. It decodes stores to the
// tohost word (and its alias) and to the console TX byte register. Console
// bytes are buffered in a FIFO that drains toward a UART/log sink. Sticky
// pass/fail/timeout status is exposed for benches and FPGA LEDs.
//
// Ports
//   clk, rst_n                 clock (posedge), asynchronous active-low reset
//   data_req_i .. data_wdata_i request side of the data port
//   data_gnt_o                 grant, combinational in the request cycle
//   data_rvalid_o/rdata_o      response, one cycle after each grant
//   char_valid_o/char_o        console byte stream (FIFO head)
//   char_ready_i               sink accepts the head byte (pop on valid&ready)
//   done_o, pass_o             sticky halt / pass indications
//   fail_code_o                tohost>>1 of the failing write, else 0
//   timeout_o                  sticky watchdog expiry
// -----------------------------------------------------------------------------
module zeroriscy_host_mmio #(
  parameter logic [31:0] TOHOST_ADDR  = 32'h8000_1000,
  parameter logic [31:0] TOHOST_ALIAS = 32'h8000_3000,
  parameter logic [31:0] CONSOLE_ADDR = 32'h9A10_0000,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [63:0] MAX_CYCLES   = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        done_o,
  output logic        pass_o,
  output logic [30:0] fail_code_o,
  output logic        timeout_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] STATUS_ADDR = CONSOLE_ADDR + 32'd4;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  logic [7:0]  fifo_mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r, count_s;
  logic        empty_s, full_s, push_s, pop_s;
  logic        is_console_s, is_status_s, is_tohost_s, tohost_store_s;
  logic        gnt_s;
  logic [31:0] be_mask_s, tohost_val_s, load_data_s, tohost_r;
  logic [1:0]  state_r, state_next_s;
  logic [63:0] cycle_cnt_r;
  logic        rvalid_r, done_r, pass_r, timeout_r;
  logic [31:0] rdata_r;
  logic [30:0] fail_code_r;

  // Address decode, FIFO flags and the grant/push/pop qualifiers.
  always_comb begin
    is_console_s   = (data_addr_i == CONSOLE_ADDR);
    is_status_s    = (data_addr_i == STATUS_ADDR);
    is_tohost_s    = (data_addr_i == TOHOST_ADDR) || (data_addr_i == TOHOST_ALIAS);
    count_s        = wr_ptr_r - rd_ptr_r;
    empty_s        = (wr_ptr_r == rd_ptr_r);
    full_s         = (count_s == (AW+1)'(FIFO_DEPTH));
    // Stall only on a console push into a FIFO that was full at the start of
    // the cycle; a concurrent pop frees the slot for the next cycle only.
    gnt_s          = rst_n & data_req_i &
                     ~(data_we_i & is_console_s & data_be_i[0] & full_s);
    push_s         = gnt_s & data_we_i & is_console_s & data_be_i[0];
    pop_s          = char_ready_i & ~empty_s;
    tohost_store_s = gnt_s & data_we_i & is_tohost_s;
    be_mask_s      = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                      {8{data_be_i[1]}}, {8{data_be_i[0]}}};
    tohost_val_s   = data_wdata_i & be_mask_s;
  end

  // Load data mux; console TX and unmapped addresses read as zero.
  always_comb begin
    load_data_s = 32'd0;
    if (is_status_s) begin
      load_data_s = {16'h0000, 8'(count_s), 4'h0, timeout_r, done_r, empty_s, full_s};
    end else if (is_tohost_s) begin
      load_data_s = tohost_r;
    end else begin
      load_data_s = 32'd0;
    end
  end

  // Halt FSM next state; a PASS/FAIL store beats a same-cycle watchdog expiry.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (tohost_store_s && (tohost_val_s != 32'd0)) begin
          state_next_s = (tohost_val_s == 32'd1) ? ST_PASS : ST_FAIL;
        end else if ((MAX_CYCLES != 64'd0) && (cycle_cnt_r == MAX_CYCLES)) begin
          state_next_s = ST_TIMEOUT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: state_next_s = state_r;
      default: state_next_s = ST_RUN;
    endcase
  end

  // FIFO storage; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= data_wdata_i[7:0];
    end
  end

  // FIFO pointers, bus response, tohost capture, FSM and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'd0;
      tohost_r    <= 32'd0;
      state_r     <= ST_RUN;
      cycle_cnt_r <= 64'd0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
      fail_code_r <= 31'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      rvalid_r <= gnt_s;
      rdata_r  <= (gnt_s && !data_we_i) ? load_data_s : 32'd0;
      if (tohost_store_s) tohost_r <= tohost_val_s;
      if (state_r == ST_RUN) cycle_cnt_r <= cycle_cnt_r + 64'd1;
      state_r   <= state_next_s;
      done_r    <= (state_next_s != ST_RUN);
      pass_r    <= (state_next_s == ST_PASS);
      timeout_r <= (state_next_s == ST_TIMEOUT);
      if ((state_r == ST_RUN) && (state_next_s == ST_FAIL)) begin
        fail_code_r <= tohost_val_s[31:1];
      end
    end
  end

  assign data_gnt_o    = gnt_s;
  assign data_rvalid_o = rvalid_r;
  assign data_rdata_o  = rdata_r;
  assign char_valid_o  = ~empty_s;
  assign char_o        = empty_s ? 8'h00 : fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign done_o        = done_r;
  assign pass_o        = pass_r;
  assign fail_code_o   = fail_code_r;
  assign timeout_o     = timeout_r;

endmodule

// File: tb/tb_zeroriscy_host_mmio.sv
// Bench for zeroriscy_host_mmio: directed scenarios plus randomized bus and
// sink traffic, every cycle compared against a queue-based reference model.
module tb_zeroriscy_host_mmio;

  localparam logic [31:0] TH    = 32'h8000_1000;
  localparam logic [31:0] AL    = 32'h8000_3000;
  localparam logic [31:0] CO    = 32'h9A10_0000;
  localparam logic [31:0] ST    = 32'h9A10_0004;
  localparam int          DEPTH = 16;
  localparam longint unsigned MAXC = 100;

  logic        clk, rst_n;
  logic        data_req_i, data_we_i, char_ready_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, char_valid_o;
  logic [31:0] data_rdata_o;
  logic [7:0]  char_o;
  logic        done_o, pass_o, timeout_o;
  logic [30:0] fail_code_o;

  zeroriscy_host_mmio #(
    .TOHOST_ADDR(TH), .TOHOST_ALIAS(AL), .CONSOLE_ADDR(CO),
    .FIFO_DEPTH(DEPTH), .MAX_CYCLES(64'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .char_valid_o(char_valid_o), .char_o(char_o), .char_ready_i(char_ready_i),
    .done_o(done_o), .pass_o(pass_o), .fail_code_o(fail_code_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  byte unsigned    q[$];
  bit              m_pass, m_failed, m_timeout, m_rvalid;
  logic [30:0]     m_code;
  logic [31:0]     m_tohost, m_rdata;
  longint unsigned m_cyc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_done();
    return m_pass | m_failed | m_timeout;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pass = 0; m_failed = 0; m_timeout = 0; m_rvalid = 0;
    m_code = '0; m_tohost = '0; m_rdata = '0; m_cyc = 0;
  endtask

  task automatic check_all_zero();
    check_eq("rst_gnt",     64'(data_gnt_o),    64'd0);
    check_eq("rst_rvalid",  64'(data_rvalid_o), 64'd0);
    check_eq("rst_rdata",   64'(data_rdata_o),  64'd0);
    check_eq("rst_cvalid",  64'(char_valid_o),  64'd0);
    check_eq("rst_char",    64'(char_o),        64'd0);
    check_eq("rst_done",    64'(done_o),        64'd0);
    check_eq("rst_pass",    64'(pass_o),        64'd0);
    check_eq("rst_fcode",   64'(fail_code_o),   64'd0);
    check_eq("rst_timeout", 64'(timeout_o),     64'd0);
  endtask

  // One clock cycle: drive at negedge, check, advance model, wait next negedge.
  task automatic cyc(input bit rq, input bit we, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] wd, input bit rdy,
                     output bit g);
    bit full, run;
    logic [31:0] st, v, mask, nrd;
    data_req_i = rq; data_we_i = we; data_be_i = be;
    data_addr_i = a; data_wdata_i = wd; char_ready_i = rdy;
    #1;
    full = (q.size() == DEPTH);
    g = rq && !(we && a == CO && be[0] && full);
    check_eq("gnt",    64'(data_gnt_o),    64'(g));
    check_eq("rvalid", 64'(data_rvalid_o), 64'(m_rvalid));
    if (m_rvalid) check_eq("rdata", 64'(data_rdata_o), 64'(m_rdata));
    check_eq("cvalid", 64'(char_valid_o), 64'(q.size() != 0));
    if (q.size() != 0) check_eq("char", 64'(char_o), 64'(q[0]));
    check_eq("done",    64'(done_o),      64'(m_done()));
    check_eq("pass",    64'(pass_o),      64'(m_pass));
    check_eq("fcode",   64'(fail_code_o), 64'(m_code));
    check_eq("timeout", 64'(timeout_o),   64'(m_timeout));
    // Advance the model by one cycle
    st   = {16'h0, 8'(q.size()), 4'h0, m_timeout, m_done(), q.size() == 0, full};
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    nrd  = 32'd0;
    if (g && !we) nrd = (a == ST) ? st : ((a == TH || a == AL) ? m_tohost : 32'd0);
    run = !m_done();
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (g && we && a == CO && be[0]) q.push_back(wd[7:0]);
    if (g && we && (a == TH || a == AL)) begin
      v = wd & mask;
      m_tohost = v;
      if (run && v != 0) begin
        if (v == 1) m_pass = 1;
        else begin m_failed = 1; m_code = v[31:1]; end
      end
    end
    if (run && !m_pass && !m_failed && MAXC != 0 && m_cyc == MAXC) m_timeout = 1;
    if (run) m_cyc++;
    m_rvalid = g;
    m_rdata  = nrd;
    @(negedge clk);
  endtask

  task automatic bus(input bit we, input logic [3:0] be, input logic [31:0] a,
                     input logic [31:0] wd, input bit rdy);
    bit g;
    int n;
    n = 0;
    do begin
      cyc(1'b1, we, be, a, wd, rdy, g);
      n++;
    end while (!g && n < 64);
    check_eq("grant_wait", 64'(g), 64'd1);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit g;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, rdy, g);
  endtask

  // Asynchronous reset mid-cycle (inputs left as they were), released at negedge.
  task automatic areset();
    #1 rst_n = 1'b0;
    #1 check_all_zero();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit g;
    logic [31:0] a, wd;
    rst_n = 1'b0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0;
    data_addr_i = 0; data_wdata_i = 0; char_ready_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;

    // Console bytes stream out in order
    bus(1, 4'hF, CO, 32'h41, 1);
    bus(1, 4'hF, CO, 32'h42, 1);
    idle(3, 1);

    // FIFO full stall; a pop releases the grant only one cycle later
    areset();
    for (int i = 0; i < DEPTH; i++) bus(1, 4'hF, CO, 32'h60 + 32'(i), 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 4'hF, CO, 32'h99, 0, g);
    cyc(1, 1, 4'hF, CO, 32'h99, 1, g);
    cyc(1, 1, 4'hF, CO, 32'h99, 0, g);
    bus(1, 4'h2, CO, 32'h77, 0);   // be[0]=0: granted even when full, ignored
    idle(20, 1);

    // PASS, then a later store changes nothing
    areset();
    bus(1, 4'hF, TH, 32'd1, 1);
    idle(1, 1);
    bus(1, 4'hF, TH, 32'd7, 1);
    bus(0, 4'hF, TH, 32'd0, 1);
    idle(2, 1);

    // FAIL via alias, readback through primary address
    areset();
    bus(1, 4'hF, AL, 32'h0000_000B, 1);
    idle(1, 1);
    bus(0, 4'hF, TH, 32'd0, 1);
    idle(2, 1);

    // Disabled byte lanes are forced to zero
    areset();
    bus(1, 4'b0010, TH, 32'hFFFF_FFFF, 1);
    bus(0, 4'hF, TH, 32'd0, 1);
    idle(2, 1);

    // Watchdog expiry and STATUS readback
    areset();
    idle(103, 1);
    bus(0, 4'hF, ST, 32'd0, 1);
    idle(2, 1);

    // tohost store on the expiry cycle wins over the watchdog
    areset();
    idle(100, 1);
    bus(1, 4'hF, TH, 32'd1, 1);
    idle(2, 1);

    // Reset with FIFO entries, done set and an rvalid pending
    areset();
    for (int i = 0; i < 3; i++) bus(1, 4'hF, CO, 32'h30 + 32'(i), 0);
    bus(1, 4'hF, TH, 32'd1, 0);
    areset();
    bus(0, 4'hF, ST, 32'd0, 1);
    idle(2, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) areset();
      case ($urandom_range(0, 5))
        0: a = TH;
        1: a = AL;
        2, 3: a = CO;
        4: a = ST;
        default: a = $urandom;
      endcase
      wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      cyc(($urandom_range(0, 2) != 0), 1'($urandom),
          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
          a, wd, ($urandom_range(0, 9) < 4), g);
    end
    idle(40, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
